deser_8: RTL
============

Name: deser_8

Overview:
- Serial-to-parallel receive end of the 8-bit register path. Takes MSB-first serial bits and assembles one byte.
- Applies the inverse of the selected byte transform, then presents the result on a valid/ready output.
- Sits downstream of the serialised register_8 output and recovers the original byte for the consumer.

Parameters:
- NBITS, 8, byte width. Fixed at 8; transforms are defined only for 8.
- CNT_W, 4, width of the internal bit counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  begin a new byte. Accepted only in IDLE.
- mode  input  2  transform to undo. Latched on accepted start:
  - 00 plain
  - 01 full bit-reverse
  - 10 reverse within each nibble
  - 11 undo shift-left (logical shift right by 1)
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is valid this cycle.
- data_out  output  8  decoded byte.
- out_valid  output  1  data_out holds a byte.
- out_ready  input  1  consumer accepts data_out.
- busy  output  1  high in SHIFT and HOLD.
- overrun  output  1  sticky flag: a bit arrived in HOLD and was dropped.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, raw=0, count=0, mode_q=00.
  - data_out=8'h00, out_valid=0, busy=0, overrun=0.
  - Reset asserted mid-operation aborts the byte immediately. No output is produced for it.
- State machine, registered on clk:
  - IDLE: busy=0. sin_valid is ignored.
    - start=1 → latch mode into mode_q, raw=0, count=0, overrun=0, go to SHIFT.
  - SHIFT: busy=1. start is ignored.
    - Each cycle with sin_valid=1: raw<={raw[6:0],sin}, count+=1.
    - Cycles with sin_valid=0 hold state; gaps are allowed.
    - On the 8th accepted bit (count==7 and sin_valid=1), in the same edge:
      - data_out<=xform(mode_q,{raw[6:0],sin})
      - out_valid<=1
      - count<=0
      - go to HOLD
  - HOLD: busy=1. out_valid=1. data_out is stable.
    - out_ready=1 → out_valid<=0, go to IDLE.
    - sin_valid=1 → overrun<=1, bit dropped. This also applies on the handshake cycle.
    - start is ignored.
- xform(m,r) is combinational and applied at the capture edge:
  - 00: r.
  - 01: {r0,r1,r2,r3,r4,r5,r6,r7}.
  - 10: {r4,r5,r6,r7,r0,r1,r2,r3}.
  - 11: {1'b0,r[7:1]}.
- Latency:
  - out_valid rises on the clock edge that samples the 8th valid bit.
  - Minimum is 9 cycles from the start edge with contiguous sin_valid: start edge plus 8 bit edges.
- Back-to-back bytes:
  - Next start is accepted no earlier than the cycle after the handshake.
  - Minimum period is 10 cycles.
- overrun:
  - Stays set until the next accepted start or reset.
  - Does not affect data_out.
- data_out holds its last value in IDLE. It changes only on capture or reset.
- mode changes after start have no effect until the next start.

Test Plan:
- mode=00, start, bits 1,0,1,1,0,0,1,0 contiguous → out_valid at cycle 9 from start, data_out=8'hB2, busy=1 until handshake.
- Same bits with mode=01 → 8'h4D. With mode=10 → 8'hD4. With mode=11 → 8'h59.
- mode=00, bits of 8'hA5 with sin_valid gaps (valid on alternate cycles) → data_out=8'hA5 after 8 valid beats. No capture on invalid cycles.
- Hold out_ready=0 for 5 cycles after capture and pulse sin_valid twice → data_out stays 8'hB2, out_valid stays 1, overrun=1. After out_ready → IDLE. Next start clears overrun to 0.
- Assert rst after 4 bits → all outputs 0 immediately, busy=0. Then a full start with bits of 8'h3C and mode=00 → 8'h3C with no residue from the aborted byte.
- Change mode from 00 to 01 mid-SHIFT and pulse start in SHIFT → start ignored. Output uses latched mode 00: bits of 8'hB2 → 8'hB2.

Source files
------------

// File: rtl/deser_8.sv
// Receive end of the 8-bit register path: assembles an MSB-first serial byte,
// undoes the selected transform and holds the result on a valid/ready output.
module deser_8 #(
  parameter int NBITS = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic             sin_i,
  input  logic             sin_valid_i,
  output logic [NBITS-1:0] data_out_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic             overrun_o
);

  // state | meaning
  // IDLE  | waiting for start, last byte still visible on data_out_o
  // SHIFT | collecting serial bits, gaps in sin_valid_i allowed
  // HOLD  | byte presented, waiting for out_ready_i; new bits are dropped
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t             state_q, state_d;
  logic [NBITS-1:0]   raw_q, raw_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [1:0]         mode_q, mode_d;
  logic [NBITS-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;
  logic [NBITS-1:0]   raw_next;
  logic [NBITS-1:0]   decoded;

  assign raw_next = {raw_q[NBITS-2:0], sin_i};

  always_comb begin
    decoded = raw_next;
    unique case (mode_q)
      2'b00: decoded = raw_next;
      2'b01: for (int i = 0; i < NBITS; i++) decoded[i] = raw_next[NBITS-1-i];
      2'b10: decoded = {raw_next[4], raw_next[5], raw_next[6], raw_next[7],
                        raw_next[0], raw_next[1], raw_next[2], raw_next[3]};
      2'b11: decoded = {1'b0, raw_next[NBITS-1:1]};
      default: decoded = raw_next;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    raw_d     = raw_q;
    count_d   = count_q;
    mode_d    = mode_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          mode_d    = mode_i;
          raw_d     = '0;
          count_d   = '0;
          overrun_d = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (sin_valid_i) begin
          raw_d = raw_next;
          if (count_q == CNT_W'(NBITS - 1)) begin
            data_d  = decoded;
            valid_d = 1'b1;
            count_d = '0;
            state_d = HOLD;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (sin_valid_i) overrun_d = 1'b1;
        if (out_ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      raw_q     <= '0;
      count_q   <= '0;
      mode_q    <= 2'b00;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      raw_q     <= raw_d;
      count_q   <= count_d;
      mode_q    <= mode_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_out_o  = data_q;
  assign out_valid_o = valid_q;
  assign busy_o      = (state_q != IDLE);
  assign overrun_o   = overrun_q;

endmodule
